// File: rtl/score_renderer_pkg.sv
// Shared definitions for the score renderer: the game-state encoding, glyph codes,
// field geometry and a helper that turns the binary winning score into BCD.
package score_renderer_pkg;

    // The encoding is also the value driven on the winner output.
    typedef enum logic [1:0] {
        StPlaying  = 2'b00,
        StLeftWon  = 2'b01,
        StRightWon = 2'b10
    } game_state_e;

    localparam int COORD_W          = 10;
    localparam int GLYPH_COLS       = 8;
    localparam int GLYPH_ROWS       = 8;
    localparam int GLYPHS_PER_FIELD = 2;
    localparam int GLYPH_CODE_W     = 4;

    // Codes 0..9 are the digits themselves.
    localparam logic [GLYPH_CODE_W-1:0] GLYPH_SMILEY = 4'd10;

    // Binary 0..99 to {tens, units} BCD. Only ever applied to a parameter.
    function automatic logic [7:0] to_bcd(input logic [6:0] value);
        return {4'(value / 7'd10), 4'(value % 7'd10)};
    endfunction

endpackage

// File: rtl/score_renderer_if.sv
// Bus between the game/video logic and the score renderer.
//   beam_x, beam_y, beam_valid : raster position of the current pixel
//   inc_left, inc_right        : one-cycle point pulses
//   score_clear                : one-cycle new-game pulse
//   pixel_on                   : score foreground pixel (2 cycles after the beam)
//   winner                     : 00 playing, 01 left won, 10 right won
// master = the driver of beam and game events, slave = the renderer.
interface score_renderer_if;
    import score_renderer_pkg::*;

    logic [COORD_W-1:0] beam_x;
    logic [COORD_W-1:0] beam_y;
    logic               beam_valid;
    logic               inc_left;
    logic               inc_right;
    logic               score_clear;
    logic               pixel_on;
    logic [1:0]         winner;

    modport master (
        output beam_x, beam_y, beam_valid, inc_left, inc_right, score_clear,
        input  pixel_on, winner
    );

    modport slave (
        input  beam_x, beam_y, beam_valid, inc_left, inc_right, score_clear,
        output pixel_on, winner
    );

endinterface

// File: rtl/bcd2_counter.sv
// Two-digit BCD score counter, 00..99, saturating at 99.
//   clk, reset_n               : clock, asynchronous active-low reset
//   i_clear                    : zero the score (wins over i_inc)
//   i_inc                      : add one point
//   o_tens, o_units            : current score
//   o_next_tens, o_next_units  : score after this edge, for same-edge win detection
module bcd2_counter (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_clear,
    input  logic       i_inc,
    output logic [3:0] o_tens,
    output logic [3:0] o_units,
    output logic [3:0] o_next_tens,
    output logic [3:0] o_next_units
);

    logic [3:0] r_tens;
    logic [3:0] r_units;

    always_comb begin
        o_next_tens  = r_tens;
        o_next_units = r_units;
        if (i_clear) begin
            o_next_tens  = 4'd0;
            o_next_units = 4'd0;
        end else if (i_inc && !(r_tens == 4'd9 && r_units == 4'd9)) begin
            if (r_units == 4'd9) begin
                o_next_units = 4'd0;
                o_next_tens  = r_tens + 4'd1;
            end else begin
                o_next_units = r_units + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tens  <= 4'd0;
            r_units <= 4'd0;
        end else begin
            r_tens  <= o_next_tens;
            r_units <= o_next_units;
        end
    end

    assign o_tens  = r_tens;
    assign o_units = r_units;

endmodule

// File: rtl/character_rom.sv
// 8x8 glyph ROM: digits 0..9 and a smiley (code 10); other codes read as blank.
// Bit n of a line is glyph column n, column 0 being the leftmost pixel.
//   i_code : glyph code
//   i_line : glyph row 0..7, row 0 at the top
//   o_bits : the eight pixels of that row
module character_rom
    import score_renderer_pkg::*;
(
    input  logic [GLYPH_CODE_W-1:0] i_code,
    input  logic [2:0]              i_line,
    output logic [GLYPH_COLS-1:0]   o_bits
);

    // One glyph per 64-bit word, row 0 in the least significant byte.
    logic [63:0] w_rows;

    always_comb begin
        w_rows = 64'h0;
        case (i_code)
            4'd0:    w_rows = 64'h003C_6666_6E76_663C;
            4'd1:    w_rows = 64'h007E_1818_1818_1C18;
            4'd2:    w_rows = 64'h007E_060C_3060_663C;
            4'd3:    w_rows = 64'h003C_6660_3860_663C;
            4'd4:    w_rows = 64'h0030_307E_363C_3830;
            4'd5:    w_rows = 64'h003C_6660_603E_067E;
            4'd6:    w_rows = 64'h003C_6666_663E_063C;
            4'd7:    w_rows = 64'h000C_0C0C_1830_607E;
            4'd8:    w_rows = 64'h003C_6666_3C66_663C;
            4'd9:    w_rows = 64'h001C_3060_7C66_663C;
            4'd10:   w_rows = 64'h3C42_99A5_81A5_423C;
            default: w_rows = 64'h0;
        endcase
    end

    assign o_bits = w_rows[{i_line, 3'b000} +: 8];

endmodule

// File: rtl/score_renderer.sv
// Two-player score keeper and on-screen renderer. Each player has a BCD score drawn
// as two scaled 8x8 glyphs; a game FSM tracks who reached WIN_SCORE first, and the
// winner's field shows a smiley instead of the score.
//   clk     : pixel clock
//   reset_n : asynchronous active-low reset
//   bus     : beam position, point/clear pulses in; pixel_on and winner out
// pixel_on follows the beam inputs by exactly two clock edges.
module score_renderer
    import score_renderer_pkg::*;
#(
    parameter logic [9:0] LEFT_X    = 10'd224,
    parameter logic [9:0] RIGHT_X   = 10'd352,
    parameter logic [9:0] TOP_Y     = 10'd16,
    parameter int         SCALE_SH  = 2,
    parameter logic [6:0] WIN_SCORE = 7'd10
) (
    input logic             clk,
    input logic             reset_n,
    score_renderer_if.slave bus
);

    localparam logic [7:0]  WIN_BCD = to_bcd(WIN_SCORE);
    localparam logic [10:0] FIELD_W = 11'(GLYPHS_PER_FIELD * GLYPH_COLS) << SCALE_SH;
    localparam logic [10:0] FIELD_H = 11'(GLYPH_ROWS) << SCALE_SH;

    // ---------------------------------------------------------------- scores + FSM
    game_state_e r_state;
    game_state_e w_state_next;
    logic        w_playing;
    logic [3:0]  w_l_tens, w_l_units, w_l_next_tens, w_l_next_units;
    logic [3:0]  w_r_tens, w_r_units, w_r_next_tens, w_r_next_units;
    logic        w_left_reach;
    logic        w_right_reach;

    assign w_playing = (r_state == StPlaying);

    bcd2_counter u_left_score (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_clear      (bus.score_clear),
        .i_inc        (bus.inc_left & w_playing),
        .o_tens       (w_l_tens),
        .o_units      (w_l_units),
        .o_next_tens  (w_l_next_tens),
        .o_next_units (w_l_next_units)
    );

    bcd2_counter u_right_score (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_clear      (bus.score_clear),
        .i_inc        (bus.inc_right & w_playing),
        .o_tens       (w_r_tens),
        .o_units      (w_r_units),
        .o_next_tens  (w_r_next_tens),
        .o_next_units (w_r_next_units)
    );

    assign w_left_reach  = ({w_l_next_tens, w_l_next_units} == WIN_BCD);
    assign w_right_reach = ({w_r_next_tens, w_r_next_units} == WIN_BCD);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StPlaying: begin
                // Left is checked first so a simultaneous win goes to the left player.
                if (w_left_reach) begin
                    w_state_next = StLeftWon;
                end else if (w_right_reach) begin
                    w_state_next = StRightWon;
                end
            end
            StLeftWon, StRightWon: w_state_next = r_state;
            default:               w_state_next = StPlaying;
        endcase
        if (bus.score_clear) begin
            w_state_next = StPlaying;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StPlaying;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign bus.winner = r_state;

    // ---------------------------------------------------------------- stage 1
    logic [10:0]         w_bx;
    logic [10:0]         w_by;
    logic                w_in_rows;
    logic                w_hit_l;
    logic                w_hit_r;
    // Only the low bits of the offsets matter; the field is a power-of-two size.
    logic [SCALE_SH+3:0] w_dx_l;
    logic [SCALE_SH+3:0] w_dx_r;
    logic [SCALE_SH+3:0] w_dx;
    logic [SCALE_SH+2:0] w_dy;
    logic                w_units_sel;
    logic [3:0]          w_tens;
    logic [3:0]          w_units;
    logic                w_is_winner;
    logic                w_blank;
    logic [GLYPH_CODE_W-1:0] w_glyph;

    assign w_bx = {1'b0, bus.beam_x};
    assign w_by = {1'b0, bus.beam_y};

    assign w_in_rows = (w_by >= {1'b0, TOP_Y}) && (w_by < {1'b0, TOP_Y} + FIELD_H);
    assign w_hit_l   = bus.beam_valid && w_in_rows &&
                       (w_bx >= {1'b0, LEFT_X}) && (w_bx < {1'b0, LEFT_X} + FIELD_W);
    assign w_hit_r   = bus.beam_valid && w_in_rows &&
                       (w_bx >= {1'b0, RIGHT_X}) && (w_bx < {1'b0, RIGHT_X} + FIELD_W);

    assign w_dx_l = bus.beam_x[SCALE_SH+3:0] - LEFT_X[SCALE_SH+3:0];
    assign w_dx_r = bus.beam_x[SCALE_SH+3:0] - RIGHT_X[SCALE_SH+3:0];
    assign w_dx   = w_hit_r ? w_dx_r : w_dx_l;
    assign w_dy   = bus.beam_y[SCALE_SH+2:0] - TOP_Y[SCALE_SH+2:0];

    // The fields never overlap, so one side's score feeds the single ROM at a time.
    assign w_units_sel = w_dx[SCALE_SH+3];
    assign w_tens      = w_hit_r ? w_r_tens : w_l_tens;
    assign w_units     = w_hit_r ? w_r_units : w_l_units;
    assign w_is_winner = w_hit_r ? (r_state == StRightWon) : (r_state == StLeftWon);

    always_comb begin
        w_blank = 1'b0;
        w_glyph = w_units;
        if (w_units_sel) begin
            if (w_is_winner) begin
                w_glyph = GLYPH_SMILEY;
            end
        end else begin
            w_glyph = w_tens;
            w_blank = (w_tens == 4'd0) || w_is_winner;
        end
    end

    logic                    r_hit;
    logic                    r_blank;
    logic [GLYPH_CODE_W-1:0] r_glyph;
    logic [2:0]              r_line;
    logic [2:0]              r_col;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hit   <= 1'b0;
            r_blank <= 1'b0;
            r_glyph <= '0;
            r_line  <= 3'd0;
            r_col   <= 3'd0;
        end else begin
            r_hit   <= w_hit_l | w_hit_r;
            r_blank <= w_blank;
            r_glyph <= w_glyph;
            r_line  <= 3'(w_dy >> SCALE_SH);
            r_col   <= 3'(w_dx >> SCALE_SH);
        end
    end

    // ---------------------------------------------------------------- stage 2
    logic [GLYPH_COLS-1:0] w_charline;
    logic                  r_pixel_on;

    character_rom u_rom (
        .i_code (r_glyph),
        .i_line (r_line),
        .o_bits (w_charline)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pixel_on <= 1'b0;
        end else begin
            r_pixel_on <= r_hit & ~r_blank & w_charline[r_col];
        end
    end

    assign bus.pixel_on = r_pixel_on;

endmodule

// File: tb/tb_score_renderer.sv
// Self-checking bench for score_renderer. A decimal score/winner model and a
// coordinate-arithmetic pixel model predict pixel_on (two edges late) and winner.
module tb_score_renderer;

    localparam int LEFT_X  = 224;
    localparam int RIGHT_X = 352;
    localparam int TOP_Y   = 16;
    localparam int SCALE   = 4;
    localparam int WIN     = 10;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    score_renderer_if bus_if ();

    score_renderer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: plain decimal scores, winner 0/1/2, and the two pipeline slots.
    int m_left;
    int m_right;
    int m_winner;
    int p1;
    int p2;
    logic [7:0] font [11][8];

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, observed, expected,
                     $time);
        end
    endtask

    function automatic int exp_pixel(input int x, input int y, input bit valid);
        int org, player, dx, dy, g, col, line, score, code;
        if (!valid) return 0;
        if (y < TOP_Y || y >= TOP_Y + 8 * SCALE) return 0;
        if (x >= LEFT_X && x < LEFT_X + 16 * SCALE) begin
            player = 1;
            org    = LEFT_X;
        end else if (x >= RIGHT_X && x < RIGHT_X + 16 * SCALE) begin
            player = 2;
            org    = RIGHT_X;
        end else begin
            return 0;
        end
        dx    = x - org;
        dy    = y - TOP_Y;
        g     = dx / (8 * SCALE);
        col   = (dx % (8 * SCALE)) / SCALE;
        line  = dy / SCALE;
        score = (player == 1) ? m_left : m_right;
        if (g == 0) begin
            if (score / 10 == 0 || m_winner == player) return 0;
            code = score / 10;
        end else begin
            code = (m_winner == player) ? 10 : score % 10;
        end
        return int'(font[code][line][col]);
    endfunction

    task automatic model_update(input bit il, input bit ir, input bit clr);
        if (clr) begin
            m_left   = 0;
            m_right  = 0;
            m_winner = 0;
        end else if (m_winner == 0) begin
            if (il && m_left < 99) m_left++;
            if (ir && m_right < 99) m_right++;
            if (m_left == WIN) m_winner = 1;
            else if (m_right == WIN) m_winner = 2;
        end
    endtask

    // Drive one beam sample plus events, clock once, check the output of two samples ago.
    task automatic cycle(input int x, input int y, input bit valid, input bit il,
                         input bit ir, input bit clr, input string tag);
        bus_if.beam_x      = 10'(x);
        bus_if.beam_y      = 10'(y);
        bus_if.beam_valid  = valid;
        bus_if.inc_left    = il;
        bus_if.inc_right   = ir;
        bus_if.score_clear = clr;
        p2 = p1;
        p1 = exp_pixel(x, y, valid);
        model_update(il, ir, clr);
        @(posedge clk);
        #1;
        check_value($sformatf("%s.pixel(%0d,%0d)", tag, x, y), 32'(bus_if.pixel_on), p2);
        check_value($sformatf("%s.winner", tag), 32'(bus_if.winner), m_winner);
    endtask

    // Raster over a window enclosing both fields with a margin, with blanking gaps.
    task automatic sweep(input string tag, input int inc_div);
        for (int y = TOP_Y - 8; y < TOP_Y + 8 * SCALE + 8; y++) begin
            for (int x = LEFT_X - 16; x < RIGHT_X + 16 * SCALE + 16; x++) begin
                bit v, il, ir;
                v  = (x % 64 != 7) && ($urandom_range(0, 15) != 0);
                il = 1'b0;
                ir = 1'b0;
                if (inc_div > 0) begin
                    il = ($urandom_range(0, inc_div - 1) == 0);
                    ir = ($urandom_range(0, inc_div - 1) == 0);
                end
                cycle(x, y, v, il, ir, 1'b0, tag);
            end
        end
    endtask

    initial begin
        font = '{
            '{8'h3C, 8'h66, 8'h76, 8'h6E, 8'h66, 8'h66, 8'h3C, 8'h00},
            '{8'h18, 8'h1C, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00},
            '{8'h3C, 8'h66, 8'h60, 8'h30, 8'h0C, 8'h06, 8'h7E, 8'h00},
            '{8'h3C, 8'h66, 8'h60, 8'h38, 8'h60, 8'h66, 8'h3C, 8'h00},
            '{8'h30, 8'h38, 8'h3C, 8'h36, 8'h7E, 8'h30, 8'h30, 8'h00},
            '{8'h7E, 8'h06, 8'h3E, 8'h60, 8'h60, 8'h66, 8'h3C, 8'h00},
            '{8'h3C, 8'h06, 8'h3E, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00},
            '{8'h7E, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h0C, 8'h0C, 8'h00},
            '{8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h00},
            '{8'h3C, 8'h66, 8'h66, 8'h7C, 8'h60, 8'h30, 8'h1C, 8'h00},
            '{8'h3C, 8'h42, 8'hA5, 8'h81, 8'hA5, 8'h99, 8'h42, 8'h3C}
        };
        m_left   = 0;
        m_right  = 0;
        m_winner = 0;
        p1       = 0;
        p2       = 0;
        bus_if.beam_x      = 10'(LEFT_X + 40);
        bus_if.beam_y      = 10'(TOP_Y);
        bus_if.beam_valid  = 1'b1;
        bus_if.inc_left    = 1'b1;
        bus_if.inc_right   = 1'b1;
        bus_if.score_clear = 1'b0;

        // Reset held with active stimulus: nothing may move.
        repeat (3) begin
            @(posedge clk);
            #1;
            check_value("reset.pixel", 32'(bus_if.pixel_on), 0);
            check_value("reset.winner", 32'(bus_if.winner), 0);
        end
        reset_n = 1'b1;

        // Score 00: tens glyph blank.
        repeat (4) cycle(LEFT_X + 4, TOP_Y + 4, 1'b1, 1'b0, 1'b0, 1'b0, "blank00");

        // Eleven left points; the beam roams the left units glyph.
        for (int i = 0; i < 11; i++) begin
            cycle(LEFT_X + 32 + int'($urandom_range(0, 31)), TOP_Y + int'($urandom_range(0, 31)),
                  1'b1, 1'b1, 1'b0, 1'b0, "inc_left");
            if (i == 9) check_value("tenth_pulse_win", 32'(bus_if.winner), 1);
            cycle(LEFT_X + 32 + int'($urandom_range(0, 31)), TOP_Y + int'($urandom_range(0, 31)),
                  1'b1, 1'b0, 1'b0, 1'b0, "idle");
        end

        // Left has won; incs must be ignored during this frame.
        sweep("won_left", 97);

        // New game, left 7 and right 9, then a static frame.
        cycle(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, "clear");
        for (int i = 0; i < 9; i++) begin
            cycle(RIGHT_X + 40, TOP_Y + 8, 1'b1, (i < 7), 1'b1, 1'b0, "to_7_9");
        end
        sweep("scores_7_9", 0);

        // Both at 09, then both score on the same edge: left takes it.
        repeat (2) cycle(LEFT_X + 40, TOP_Y, 1'b1, 1'b1, 1'b0, 1'b0, "to_9_9");
        cycle(LEFT_X + 40, TOP_Y, 1'b1, 1'b1, 1'b1, 1'b0, "tie");
        check_value("tie_left_wins", 32'(bus_if.winner), 1);

        // Clear wins over a coincident right point.
        cycle(RIGHT_X + 40, TOP_Y, 1'b1, 1'b0, 1'b1, 1'b1, "clear_vs_inc");
        check_value("clear_vs_inc_winner", 32'(bus_if.winner), 0);
        repeat (3) cycle(RIGHT_X + 40, TOP_Y, 1'b1, 1'b0, 1'b0, 1'b0, "after_clear");

        // Frame with scores changing mid-raster.
        sweep("live", 300);

        // Random beam and events.
        for (int i = 0; i < 2000; i++) begin
            int x, y;
            bit il, ir, clr, v;
            if ($urandom_range(0, 7) == 0) x = int'($urandom_range(0, 1023));
            else if ($urandom_range(0, 1) == 1) x = LEFT_X - 2 + int'($urandom_range(0, 67));
            else x = RIGHT_X - 2 + int'($urandom_range(0, 67));
            y   = TOP_Y - 2 + int'($urandom_range(0, 35));
            v   = ($urandom_range(0, 9) != 0);
            il  = ($urandom_range(0, 15) == 0);
            ir  = ($urandom_range(0, 15) == 0);
            clr = ($urandom_range(0, 199) == 0);
            cycle(x, y, v, il, ir, clr, "random");
        end

        // Left at 5, beam parked on a lit pixel, then reset pulsed between edges.
        cycle(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, "pre_reset_clear");
        for (int i = 0; i < 5; i++) cycle(LEFT_X + 40, TOP_Y, 1'b1, 1'b1, 1'b0, 1'b0, "to_5");
        repeat (3) cycle(LEFT_X + 40, TOP_Y, 1'b1, 1'b0, 1'b0, 1'b0, "lit");
        check_value("lit_before_reset", 32'(bus_if.pixel_on), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_value("async_reset.pixel", 32'(bus_if.pixel_on), 0);
        check_value("async_reset.winner", 32'(bus_if.winner), 0);
        m_left   = 0;
        m_right  = 0;
        m_winner = 0;
        p1       = 0;
        p2       = 0;
        @(posedge clk);
        #1;
        check_value("in_reset.pixel", 32'(bus_if.pixel_on), 0);
        reset_n = 1'b1;
        repeat (4) cycle(LEFT_X + 40, TOP_Y, 1'b1, 1'b0, 1'b0, 1'b0, "post_reset");
        repeat (2) cycle(LEFT_X + 4, TOP_Y + 4, 1'b1, 1'b0, 1'b0, 1'b0, "post_reset_tens");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
